// File: rtl/qrs_pkg.sv
// Shared constants and helpers for the QRS adaptive-threshold generator.
// The per-scale datapath is built on the mag_t magnitude type defined here.
package qrs_pkg;

  localparam int NUM_SCALES = 4;
  localparam int COEF_W     = 16;
  localparam int MPAVG_W    = 32;

  typedef logic [COEF_W-1:0] mag_t;

  // |x| with the single unrepresentable case (most negative value) clamped to the largest positive
  function automatic mag_t sat_abs16(input logic signed [COEF_W-1:0] x);
    mag_t r;
    r = mag_t'(x);
    if (x[COEF_W-1]) begin
      if (x == {1'b1, {(COEF_W-1){1'b0}}}) r = {1'b0, {(COEF_W-1){1'b1}}};
      else                                 r = mag_t'(-x);
    end
    return r;
  endfunction

endpackage

// File: rtl/qrs_threshold_gen_if.sv
// Bus between the wavelet filter bank (detail samples in) and the comparator (thresholds out).
// The master modport drives samples; the slave modport is the threshold generator.
interface qrs_threshold_gen_if;
  import qrs_pkg::*;

  logic                      sample_valid;
  logic signed [COEF_W-1:0]  d1, d2, d3, d4;
  logic                      win_restart;
  logic [COEF_W-1:0]         Vt1, Vt2, Vt3, Vt4;
  logic [MPAVG_W-1:0]        MPavg;
  logic                      thr_valid;

  modport master (
    output sample_valid, d1, d2, d3, d4, win_restart,
    input  Vt1, Vt2, Vt3, Vt4, MPavg, thr_valid
  );

  modport slave (
    input  sample_valid, d1, d2, d3, d4, win_restart,
    output Vt1, Vt2, Vt3, Vt4, MPavg, thr_valid
  );

endinterface

// File: rtl/qrs_peak_history.sv
// Ring buffer of per-window peaks for one scale, with a running sum kept alongside.
// sum_next is the sum as it will be after a push of din, so the caller can register Vt in the same edge.
module qrs_peak_history
  import qrs_pkg::*;
#(
  parameter int                HIST_DEPTH = 8,
  parameter logic [COEF_W-1:0] INIT_PEAK  = 16'h0040
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   push,
  input  mag_t                                   din,
  output logic [COEF_W+$clog2(HIST_DEPTH)-1:0]   sum_next
);

  localparam int HIST_W = $clog2(HIST_DEPTH);
  localparam int SUM_W  = COEF_W + HIST_W;

  mag_t              ring [HIST_DEPTH];
  logic [HIST_W-1:0] wptr;
  logic [SUM_W-1:0]  sum;

  // The entry under wptr is always the oldest, so it is the one leaving the sum
  assign sum_next = sum + SUM_W'(din) - SUM_W'(ring[wptr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) ring[i] <= INIT_PEAK;
      wptr <= '0;
      sum  <= SUM_W'(INIT_PEAK) << HIST_W;
    end else if (push) begin
      ring[wptr] <= din;
      wptr       <= wptr + 1'b1;
      sum        <= sum_next;
    end
  end

endmodule

// File: rtl/qrs_threshold_gen.sv
// Adaptive-threshold producer: windows the four wavelet detail scales, tracks per-window peaks,
// and publishes per-scale thresholds plus the window mean of |d2|+|d3|+|d4|.
module qrs_threshold_gen
  import qrs_pkg::*;
#(
  parameter int                WIN_LEN    = 256,
  parameter int                HIST_DEPTH = 8,
  parameter int                THR_SHIFT  = 1,
  parameter logic [COEF_W-1:0] INIT_PEAK  = 16'h0040
) (
  input  logic               clk,
  input  logic               rst_n,
  qrs_threshold_gen_if.slave bus
);

  localparam int CNT_W  = $clog2(WIN_LEN);
  localparam int HIST_W = $clog2(HIST_DEPTH);
  localparam int SUM_W  = COEF_W + HIST_W;
  localparam int ADD_W  = COEF_W + 2;
  localparam int ACC_W  = ADD_W + CNT_W;
  localparam logic [COEF_W-1:0] VT_RESET = INIT_PEAK >> THR_SHIFT;

  logic signed [COEF_W-1:0] d [NUM_SCALES];
  logic                     s1_valid;
  mag_t                     a [NUM_SCALES];
  mag_t                     m [NUM_SCALES];
  mag_t                     m_upd [NUM_SCALES];
  logic [CNT_W-1:0]         cnt;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_upd;
  logic [ADD_W-1:0]         add3;
  logic                     s2_take;
  logic                     window_close;
  logic [SUM_W-1:0]         sum_next [NUM_SCALES];
  mag_t                     vt_q [NUM_SCALES];
  logic [MPAVG_W-1:0]       mpavg_q;
  logic                     commit_q;

  assign d[0] = bus.d1;
  assign d[1] = bus.d2;
  assign d[2] = bus.d3;
  assign d[3] = bus.d4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int k = 0; k < NUM_SCALES; k++) a[k] <= '0;
    end else begin
      s1_valid <= bus.sample_valid;
      if (bus.sample_valid) begin
        for (int k = 0; k < NUM_SCALES; k++) a[k] <= sat_abs16(d[k]);
      end
    end
  end

  // A restart drops whatever sits in stage 1; a sample arriving with the restart is kept as sample 0
  always_comb begin
    s2_take      = s1_valid && !bus.win_restart;
    window_close = s2_take && (cnt == CNT_W'(WIN_LEN - 1));
    for (int k = 0; k < NUM_SCALES; k++) m_upd[k] = (a[k] > m[k]) ? a[k] : m[k];
    add3    = ADD_W'(a[1]) + ADD_W'(a[2]) + ADD_W'(a[3]);
    acc_upd = acc + ACC_W'(add3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      for (int k = 0; k < NUM_SCALES; k++) m[k] <= '0;
    end else if (bus.win_restart || window_close) begin
      cnt <= '0;
      acc <= '0;
      for (int k = 0; k < NUM_SCALES; k++) m[k] <= '0;
    end else if (s2_take) begin
      cnt <= cnt + 1'b1;
      acc <= acc_upd;
      for (int k = 0; k < NUM_SCALES; k++) m[k] <= m_upd[k];
    end
  end

  for (genvar k = 0; k < NUM_SCALES; k++) begin : g_hist
    qrs_peak_history #(
      .HIST_DEPTH (HIST_DEPTH),
      .INIT_PEAK  (INIT_PEAK)
    ) u_hist (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (window_close),
      .din      (m_upd[k]),
      .sum_next (sum_next[k])
    );
  end

  // Outputs load on the edge that absorbs the final sample, so the commit cycle already shows them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q <= 1'b0;
      mpavg_q  <= '0;
      for (int k = 0; k < NUM_SCALES; k++) vt_q[k] <= VT_RESET;
    end else begin
      commit_q <= window_close;
      if (window_close) begin
        mpavg_q <= MPAVG_W'(acc_upd >> CNT_W);
        for (int k = 0; k < NUM_SCALES; k++) vt_q[k] <= COEF_W'((sum_next[k] >> HIST_W) >> THR_SHIFT);
      end
    end
  end

  assign bus.Vt1       = vt_q[0];
  assign bus.Vt2       = vt_q[1];
  assign bus.Vt3       = vt_q[2];
  assign bus.Vt4       = vt_q[3];
  assign bus.MPavg     = mpavg_q;
  assign bus.thr_valid = commit_q;

endmodule

// File: tb/tb_qrs_threshold_gen.sv
// Directed bench for qrs_threshold_gen with a window/history model feeding a scoreboard of commits.
// Every negative edge compares thr_valid and all outputs against the model's current view.
module tb_qrs_threshold_gen;

  localparam int WIN = 16;
  localparam int HD  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qrs_threshold_gen_if bus();

  qrs_threshold_gen #(
    .WIN_LEN    (WIN),
    .HIST_DEPTH (HD),
    .THR_SHIFT  (1),
    .INIT_PEAK  (16'h0040)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int               due;
    logic [3:0][15:0] vt;
    logic [31:0]      mp;
  } exp_t;

  exp_t             sb[$];
  int               cyc    = 0;
  int               errors = 0;
  int               checks = 0;
  logic [3:0][15:0] cur_vt;
  logic [31:0]      cur_mp;
  int               mhist [4][HD];
  int               wp [4];
  int               mm [4];
  int               macc;
  int               mcnt;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int tb_abs(input logic signed [15:0] x);
    int v;
    v = int'(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear_window();
    for (int k = 0; k < 4; k++) mm[k] = 0;
    macc = 0;
    mcnt = 0;
  endfunction

  function automatic void model_reset();
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      cur_vt[k] = 16'h0020;
      wp[k]     = 0;
      for (int i = 0; i < HD; i++) mhist[k][i] = 'h40;
    end
    cur_mp = '0;
    model_clear_window();
  endfunction

  function automatic void model_sample(input logic signed [15:0] x1, x2, x3, x4);
    int   a [4];
    int   s;
    exp_t e;
    a[0] = tb_abs(x1);
    a[1] = tb_abs(x2);
    a[2] = tb_abs(x3);
    a[3] = tb_abs(x4);
    for (int k = 0; k < 4; k++) if (a[k] > mm[k]) mm[k] = a[k];
    macc += a[1] + a[2] + a[3];
    mcnt++;
    if (mcnt == WIN) begin
      for (int k = 0; k < 4; k++) begin
        mhist[k][wp[k]] = mm[k];
        wp[k] = (wp[k] + 1) % HD;
        s = 0;
        for (int i = 0; i < HD; i++) s += mhist[k][i];
        e.vt[k] = 16'((s / HD) / 2);
      end
      e.mp  = 32'(macc / WIN);
      e.due = cyc + 2;
      sb.push_back(e);
      model_clear_window();
    end
  endfunction

  // Drives one cycle of inputs starting just after a rising edge
  task automatic apply_stimulus(input logic v, input logic signed [15:0] x1, x2, x3, x4, input logic rs);
    bus.sample_valid = v;
    bus.d1 = x1;
    bus.d2 = x2;
    bus.d3 = x3;
    bus.d4 = x4;
    bus.win_restart = rs;
    if (rs) model_clear_window();
    if (v) model_sample(x1, x2, x3, x4);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.win_restart  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 16'sh0, 16'sh0, 16'sh0, 16'sh0, 1'b0);
  endtask

  task automatic send_same(input int n, input logic signed [15:0] x);
    repeat (n) apply_stimulus(1'b1, x, x, x, x, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard side: pops a commit when its cycle comes due, then checks every output
  initial forever begin
    logic exp_tv;
    exp_t e;
    @(negedge clk);
    exp_tv = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e      = sb.pop_front();
      cur_vt = e.vt;
      cur_mp = e.mp;
      exp_tv = 1'b1;
    end
    check_output("thr_valid", {31'b0, bus.thr_valid}, {31'b0, exp_tv});
    check_output("Vt1", {16'b0, bus.Vt1}, {16'b0, cur_vt[0]});
    check_output("Vt2", {16'b0, bus.Vt2}, {16'b0, cur_vt[1]});
    check_output("Vt3", {16'b0, bus.Vt3}, {16'b0, cur_vt[2]});
    check_output("Vt4", {16'b0, bus.Vt4}, {16'b0, cur_vt[3]});
    check_output("MPavg", bus.MPavg, cur_mp);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [15:0] r1, r2, r3, r4;
    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.win_restart  = 1'b0;
    bus.d1 = '0;
    bus.d2 = '0;
    bus.d3 = '0;
    bus.d4 = '0;
    model_reset();

    $display("[TB] test 1: reset values, partial window");
    @(posedge clk);
    #1;
    check_output("rst_Vt1", {16'b0, bus.Vt1}, 32'h20);
    check_output("rst_Vt4", {16'b0, bus.Vt4}, 32'h20);
    check_output("rst_MPavg", bus.MPavg, 32'h0);
    check_output("rst_thr_valid", {31'b0, bus.thr_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_same(15, 16'sh0123);
    idle(4);

    $display("[TB] test 2: constant window");
    do_reset(2);
    send_same(16, 16'sh0040);
    idle(4);
    check_output("t2_Vt1", {16'b0, bus.Vt1}, 32'h20);
    check_output("t2_Vt3", {16'b0, bus.Vt3}, 32'h20);
    check_output("t2_MPavg", bus.MPavg, 32'hC0);

    $display("[TB] test 3: single d3 peak with gaps");
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) apply_stimulus(1'b1, 16'sh0, 16'sh0, -16'sh0200, 16'sh0, 1'b0);
      else        apply_stimulus(1'b1, 16'sh0, 16'sh0, 16'sh0, 16'sh0, 1'b0);
      if (i % 4 == 3) idle(i % 3 + 1);
    end
    idle(4);
    check_output("t3_Vt3", {16'b0, bus.Vt3}, 32'h3C);
    check_output("t3_Vt1", {16'b0, bus.Vt1}, 32'h1C);
    check_output("t3_Vt2", {16'b0, bus.Vt2}, 32'h1C);
    check_output("t3_Vt4", {16'b0, bus.Vt4}, 32'h1C);
    check_output("t3_MPavg", bus.MPavg, 32'h20);

    $display("[TB] test 4: saturating d1 over full history");
    do_reset(2);
    for (int w = 0; w < 8; w++) begin
      repeat (16) apply_stimulus(1'b1, 16'sh8000, 16'sh0, 16'sh0, 16'sh0, 1'b0);
      idle(w % 3);
    end
    idle(4);
    check_output("t4_Vt1", {16'b0, bus.Vt1}, 32'h3FFF);

    $display("[TB] test 5: window restart");
    do_reset(2);
    send_same(10, 16'sh0300);
    apply_stimulus(1'b0, 16'sh0, 16'sh0, 16'sh0, 16'sh0, 1'b1);
    send_same(16, 16'sh0);
    idle(4);
    check_output("t5_MPavg", bus.MPavg, 32'h0);
    check_output("t5_Vt1", {16'b0, bus.Vt1}, 32'h1C);
    check_output("t5_Vt4", {16'b0, bus.Vt4}, 32'h1C);
    send_same(5, 16'sh0100);
    apply_stimulus(1'b1, 16'sh0010, 16'sh0010, 16'sh0010, 16'sh0010, 1'b1);
    send_same(15, 16'sh0008);
    idle(4);

    $display("[TB] test 6: reset mid-window and during commit");
    do_reset(2);
    send_same(8, 16'sh0400);
    do_reset(2);
    send_same(16, 16'sh0500);
    @(posedge clk);
    #1;
    do_reset(1);
    send_same(16, 16'sh0040);
    idle(4);
    check_output("t6_Vt2", {16'b0, bus.Vt2}, 32'h20);
    check_output("t6_MPavg", bus.MPavg, 32'hC0);

    $display("[TB] test 7: back-to-back windows");
    do_reset(2);
    for (int i = 0; i < 48; i++) begin
      r1 = (i % 7 == 0) ? 16'sh8000 : 16'($urandom);
      r2 = 16'($urandom);
      r3 = 16'($urandom);
      r4 = (i % 11 == 0) ? 16'sh8000 : 16'($urandom);
      apply_stimulus(1'b1, r1, r2, r3, r4, 1'b0);
    end
    idle(4);
    check_output("t7_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
